// File: rtl/lii_mem_endpoint.sv
// Memory-side LII endpoint: decodes MSB-packed READ/WRITE headers, services them on a local
// single-port memory and returns read-data flits or a write ack. Optional macro: LII_MEM_EP_ERR_CNT_EN.
module lii_mem_endpoint #(
  parameter int AXI_AW = 48,
  parameter int AXI_DW = 8,
  parameter int LII_DW = 256,
  parameter int MEM_AW = 12,
  parameter logic [AXI_AW-1:0] BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [LII_DW-1:0]   lii_req_tdata,
  input  logic [LII_DW/8-1:0] lii_req_tkeep,
  input  logic [LII_DW/8-1:0] lii_req_tstrb,
  input  logic                lii_req_tlast,
  input  logic                lii_req_tvalid,
  input  logic [7:0]          lii_req_src,
  input  logic [7:0]          lii_req_dst,
  output logic                lii_req_tready,
  output logic [LII_DW-1:0]   lii_resp_tdata,
  output logic [LII_DW/8-1:0] lii_resp_tkeep,
  output logic [LII_DW/8-1:0] lii_resp_tstrb,
  output logic                lii_resp_tlast,
  output logic                lii_resp_tvalid,
  output logic [7:0]          lii_resp_src,
  output logic [7:0]          lii_resp_dst,
  input  logic                lii_resp_tready,
`ifdef LII_MEM_EP_ERR_CNT_EN
  input  logic [7:0]          cfg_src,
  output logic [15:0]         err_cnt
`else
  input  logic [7:0]          cfg_src
`endif
);

  localparam int BYTES = AXI_DW / 8;
  localparam int KW    = LII_DW / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int MSB   = LII_DW - 1;
  localparam int AXW   = AXI_AW + 1;
  localparam logic [2:0]    LB3  = 3'(LB);
  localparam logic [KW-1:0] KEEP = KW'({BYTES{1'b1}});

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_ISSUE = 3'd1;
  localparam logic [2:0] S_RD_SEND  = 3'd2;
  localparam logic [2:0] S_WR_DATA  = 3'd3;
  localparam logic [2:0] S_WR_RESP  = 3'd4;
  localparam logic [2:0] S_DROP     = 3'd5;

  logic [2:0]        state;
  logic [8:0]        cnt;
  logic              err;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [AXI_AW-1:0] addr_q;
  logic [AXI_DW-1:0] mem [0:2**MEM_AW-1];

  logic [1:0]        h_op;
  logic [7:0]        h_len;
  logic [2:0]        h_size;
  logic [AXI_AW-1:0] h_addr;
  logic [AXW-1:0]    beat_addr, offset;
  logic [MEM_AW-1:0] widx;
  logic              in_range, size_bad, rd_bad, wr_err, last_cnt, mem_we;

  assign h_op   = lii_req_tdata[MSB -: 2];
  assign h_len  = lii_req_tdata[MSB-2 -: 8];
  assign h_size = lii_req_tdata[MSB-10 -: 3];
  assign h_addr = lii_req_tdata[MSB-13 -: AXI_AW];

  // Address math is one bit wider than AXI_AW so a run past the top never wraps into range.
  assign beat_addr = {1'b0, addr_q} + ({{(AXW-9){1'b0}}, cnt} << LB);
  assign offset    = beat_addr - {1'b0, BASE_ADDR};
  assign in_range  = (beat_addr >= {1'b0, BASE_ADDR}) && ((offset >> (LB + MEM_AW)) == '0);
  assign widx      = offset[LB +: MEM_AW];
  assign size_bad  = size_q > LB3;
  assign rd_bad    = !in_range || size_bad;
  assign last_cnt  = cnt == {1'b0, len_q};
  assign wr_err    = !in_range || (cnt > {1'b0, len_q}) || (lii_req_tlast && !last_cnt);
  assign mem_we    = rstn && (state == S_WR_DATA) && lii_req_tvalid && in_range && !size_bad &&
                     (cnt <= {1'b0, len_q});

  assign lii_req_tready = rstn && ((state == S_IDLE) || (state == S_WR_DATA) || (state == S_DROP));
  assign lii_resp_src   = rstn ? cfg_src : '0;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < BYTES; b++)
        if (lii_req_tstrb[b]) mem[widx][8*b +: 8] <= lii_req_tdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state           <= S_IDLE;
      cnt             <= '0;
      err             <= 1'b0;
      len_q           <= '0;
      size_q          <= '0;
      addr_q          <= '0;
      lii_resp_dst    <= '0;
      lii_resp_tdata  <= '0;
      lii_resp_tkeep  <= '0;
      lii_resp_tstrb  <= '0;
      lii_resp_tlast  <= 1'b0;
      lii_resp_tvalid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (lii_req_tvalid) begin
          len_q        <= h_len;
          size_q       <= h_size;
          addr_q       <= h_addr;
          lii_resp_dst <= lii_req_src;
          cnt          <= '0;
          err          <= h_size > LB3;
          if (h_op == 2'b00 && lii_req_tlast) state <= S_RD_ISSUE;
          else if (h_op == 2'b01 && !lii_req_tlast) state <= S_WR_DATA;
          else if (h_op == 2'b01) begin
            state           <= S_WR_RESP;
            lii_resp_tvalid <= 1'b1;
            lii_resp_tlast  <= 1'b1;
            lii_resp_tdata  <= LII_DW'(2'b10);
            lii_resp_tkeep  <= '0;
            lii_resp_tstrb  <= '0;
          end else state <= S_DROP;
        end
        S_RD_ISSUE: begin
          lii_resp_tvalid <= 1'b1;
          lii_resp_tdata  <= rd_bad ? '0 : LII_DW'(mem[widx]);
          lii_resp_tkeep  <= KEEP;
          lii_resp_tstrb  <= KEEP;
          lii_resp_tlast  <= last_cnt;
          err             <= err | rd_bad;
          state           <= S_RD_SEND;
        end
        S_RD_SEND: if (lii_resp_tready) begin
          lii_resp_tvalid <= 1'b0;
          lii_resp_tlast  <= 1'b0;
          if (lii_resp_tlast) state <= S_IDLE;
          else begin
            cnt   <= cnt + 9'd1;
            state <= S_RD_ISSUE;
          end
        end
        S_WR_DATA: if (lii_req_tvalid) begin
          err <= err | wr_err;
          if (cnt != '1) cnt <= cnt + 9'd1;
          if (lii_req_tlast) begin
            state           <= S_WR_RESP;
            lii_resp_tvalid <= 1'b1;
            lii_resp_tlast  <= 1'b1;
            lii_resp_tdata  <= LII_DW'((err | wr_err) ? 2'b10 : 2'b00);
            lii_resp_tkeep  <= '0;
            lii_resp_tstrb  <= '0;
          end
        end
        S_WR_RESP: if (lii_resp_tready) begin
          lii_resp_tvalid <= 1'b0;
          lii_resp_tlast  <= 1'b0;
          lii_resp_tdata  <= '0;
          state           <= S_IDLE;
        end
        S_DROP: if (lii_req_tvalid && lii_req_tlast) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LII_MEM_EP_ERR_CNT_EN
  logic err_evt;

  // One event per SLVERR ack, per erroneous read packet (at its last beat), per dropped packet.
  always_comb begin
    err_evt = 1'b0;
    case (state)
      S_IDLE:    err_evt = lii_req_tvalid && !((h_op == 2'b00 && lii_req_tlast) || h_op == 2'b01);
      S_RD_SEND: err_evt = lii_resp_tready && lii_resp_tlast && err;
      S_WR_RESP: err_evt = lii_resp_tready && lii_resp_tdata[1];
      default:   err_evt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) err_cnt <= '0;
    else if (err_evt && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_lii_mem_endpoint.sv
// Directed bench for lii_mem_endpoint: writes, reads, stalls, range/size errors, drop and reset.
module tb_lii_mem_endpoint;

  logic         clk = 1'b0;
  logic         rstn;
  logic [255:0] req_tdata;
  logic [31:0]  req_tkeep, req_tstrb;
  logic         req_tlast, req_tvalid;
  logic [7:0]   req_src, req_dst;
  logic         req_tready;
  logic [255:0] resp_tdata;
  logic [31:0]  resp_tkeep, resp_tstrb;
  logic         resp_tlast, resp_tvalid;
  logic [7:0]   resp_src, resp_dst;
  logic         resp_tready;
  logic [7:0]   cfg_src;
`ifdef LII_MEM_EP_ERR_CNT_EN
  logic [15:0]  err_cnt;
  int           exp_err = 0;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [7:0] ex [8];
  logic [7:0] wd [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lii_mem_endpoint dut (
    .clk(clk), .rstn(rstn),
    .lii_req_tdata(req_tdata), .lii_req_tkeep(req_tkeep), .lii_req_tstrb(req_tstrb),
    .lii_req_tlast(req_tlast), .lii_req_tvalid(req_tvalid),
    .lii_req_src(req_src), .lii_req_dst(req_dst), .lii_req_tready(req_tready),
    .lii_resp_tdata(resp_tdata), .lii_resp_tkeep(resp_tkeep), .lii_resp_tstrb(resp_tstrb),
    .lii_resp_tlast(resp_tlast), .lii_resp_tvalid(resp_tvalid),
    .lii_resp_src(resp_src), .lii_resp_dst(resp_dst), .lii_resp_tready(resp_tready),
`ifdef LII_MEM_EP_ERR_CNT_EN
    .cfg_src(cfg_src), .err_cnt(err_cnt)
`else
    .cfg_src(cfg_src)
`endif
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] hdr(input logic [1:0] op, input logic [7:0] len,
                                       input logic [2:0] size, input logic [47:0] addr);
    logic [255:0] h;
    h = '0;
    h[255:254] = op;
    h[253:246] = len;
    h[245:243] = size;
    h[242:195] = addr;
    h[194:187] = 8'hC3;
    return h;
  endfunction

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send_flit(input logic [255:0] d, input logic [31:0] s, input logic last,
                           output int hs);
    req_tdata = d; req_tstrb = s; req_tkeep = s; req_tlast = last; req_tvalid = 1'b1;
    for (int i = 0; i < 100 && !req_tready; i++) @(negedge clk);
    chk("req_tready", 256'(req_tready), 256'(1));
    hs = cyc;
    @(negedge clk);
    req_tvalid = 1'b0; req_tlast = 1'b0;
  endtask

  task automatic recv(output logic [255:0] d, output logic [31:0] k, output logic l, output int c);
    for (int i = 0; i < 100 && !resp_tvalid; i++) @(negedge clk);
    chk("resp_tvalid_timeout", 256'(resp_tvalid), 256'(1));
    d = resp_tdata; k = resp_tkeep; l = resp_tlast; c = cyc;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [47:0] addr, input logic [7:0] len, input int n, output int hs);
    send_flit(hdr(2'b01, len, 3'd0, addr), '0, n == 0, hs);
    for (int i = 0; i < n; i++) send_flit(256'(wd[i]), 32'h1, i == n - 1, hs);
  endtask

  task automatic chk_ack(input int hs, input logic [1:0] code, input string tag);
    logic [255:0] d; logic [31:0] k; logic l; int c;
    recv(d, k, l, c);
    chk({tag, "_lat"}, 256'(c), 256'(hs + 1));
    chk({tag, "_code"}, d, 256'(code));
    chk({tag, "_keep"}, 256'(k), 256'(0));
    chk({tag, "_last"}, 256'(l), 256'(1));
  endtask

  task automatic do_read(input logic [47:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input string tag);
    logic [255:0] d; logic [31:0] k; logic l; int c, hs, prev;
    send_flit(hdr(2'b00, len, size, addr), '0, 1'b1, hs);
    prev = hs;
    for (int b = 0; b <= int'(len); b++) begin
      recv(d, k, l, c);
      chk({tag, "_lat"}, 256'(c), 256'(prev + 2));
      chk({tag, "_data"}, d, 256'(ex[b]));
      chk({tag, "_keep"}, 256'(k), 256'(32'h1));
      chk({tag, "_last"}, 256'(l), 256'(b == int'(len)));
      prev = c;
    end
  endtask

  task automatic quiet(input int n, input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      seen = seen | resp_tvalid;
      @(negedge clk);
    end
    chk(tag, 256'(seen), 256'(0));
  endtask

  initial begin
    int hs, n;
    logic pend;
    logic [255:0] held;
    rstn = 1'b0; req_tdata = '0; req_tkeep = '0; req_tstrb = '0; req_tlast = 1'b0;
    req_tvalid = 1'b0; req_src = 8'h33; req_dst = 8'h5A; resp_tready = 1'b1; cfg_src = 8'h5A;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", 256'(resp_tvalid), 256'(0));
    chk("rst_req_tready", 256'(req_tready), 256'(0));
    chk("rst_resp_src", 256'(resp_src), 256'(0));
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_req_tready", 256'(req_tready), 256'(1));
    chk("resp_src", 256'(resp_src), 256'(8'h5A));

    // Write 11..44 at 0x10, read it back
    wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33; wd[3] = 8'h44;
    do_write(48'h10, 8'd3, 4, hs);
    chk("wr_dst", 256'(resp_dst), 256'(8'h33));
    chk_ack(hs, 2'b00, "wr_ok");
    ex[0] = 8'h11; ex[1] = 8'h22; ex[2] = 8'h33; ex[3] = 8'h44;
    do_read(48'h10, 8'd3, 3'd0, "rd4");

    // Random back-pressure on a 4-beat read
    send_flit(hdr(2'b00, 8'd3, 3'd0, 48'h10), '0, 1'b1, hs);
    n = 0; pend = 1'b0; held = '0;
    for (int i = 0; i < 300 && n < 4; i++) begin
      resp_tready = 1'($urandom_range(0, 1));
      if (pend) chk("stall_hold_valid", 256'(resp_tvalid), 256'(1));
      if (resp_tvalid) begin
        if (pend) chk("stall_stable", resp_tdata, held);
        if (resp_tready) begin
          chk("stall_data", resp_tdata, 256'(ex[n]));
          chk("stall_last", 256'(resp_tlast), 256'(n == 3));
          n++; pend = 1'b0;
        end else begin
          pend = 1'b1; held = resp_tdata;
        end
      end
      @(negedge clk);
    end
    chk("stall_beats", 256'(n), 256'(4));
    resp_tready = 1'b1;
    quiet(6, "stall_extra_beat");

    // Write crossing the top of memory; word 0 must not be touched
    wd[0] = 8'hA5;
    do_write(48'h0, 8'd0, 1, hs);
    chk_ack(hs, 2'b00, "wr_w0");
    wd[0] = 8'h5C; wd[1] = 8'h77;
    do_write(48'hFFF, 8'd1, 2, hs);
    chk_ack(hs, 2'b10, "wr_top");
    ex[0] = 8'h5C; ex[1] = 8'h00;
    do_read(48'hFFF, 8'd1, 3'd0, "rd_top");
    ex[0] = 8'hA5;
    do_read(48'h0, 8'd0, 3'd0, "rd_w0");
`ifdef LII_MEM_EP_ERR_CNT_EN
    exp_err += 2;
    chk("err_cnt_top", 256'(err_cnt), 256'(exp_err));
`endif

    // Early tlast (len=2, two flits) then illegal-size read
    wd[0] = 8'h66; wd[1] = 8'h67;
    do_write(48'h20, 8'd2, 2, hs);
    chk_ack(hs, 2'b10, "wr_early");
    ex[0] = 8'h00;
    do_read(48'h10, 8'd0, 3'd3, "rd_size3");
    ex[0] = 8'h66; ex[1] = 8'h67;
    do_read(48'h20, 8'd1, 3'd0, "rd_early");
`ifdef LII_MEM_EP_ERR_CNT_EN
    exp_err += 2;
    chk("err_cnt_early", 256'(err_cnt), 256'(exp_err));
`endif

    // op=11 packet is dropped silently
    send_flit(hdr(2'b11, 8'd2, 3'd0, 48'h10), '0, 1'b0, hs);
    send_flit(256'(8'hEE), 32'h1, 1'b0, hs);
    send_flit(256'(8'hEE), 32'h1, 1'b0, hs);
    send_flit(256'(8'hEE), 32'h1, 1'b1, hs);
    quiet(6, "drop_no_resp");
    ex[0] = 8'h11;
    do_read(48'h10, 8'd0, 3'd0, "rd_after_drop");

    // WRITE header carrying tlast has no data -> SLVERR
    do_write(48'h30, 8'd0, 0, hs);
    chk_ack(hs, 2'b10, "wr_nodata");
`ifdef LII_MEM_EP_ERR_CNT_EN
    exp_err += 2;
    chk("err_cnt_drop", 256'(err_cnt), 256'(exp_err));
`endif

    // Reset while a read beat is stalled
    resp_tready = 1'b0;
    send_flit(hdr(2'b00, 8'd3, 3'd0, 48'h10), '0, 1'b1, hs);
    for (int i = 0; i < 20 && !resp_tvalid; i++) @(negedge clk);
    chk("pre_rst_valid", 256'(resp_tvalid), 256'(1));
    rstn = 1'b0;
    @(negedge clk);
    chk("rst_mid_tvalid", 256'(resp_tvalid), 256'(0));
    chk("rst_mid_tdata", resp_tdata, '0);
    chk("rst_mid_req_tready", 256'(req_tready), 256'(0));
    chk("rst_mid_dst", 256'(resp_dst), 256'(0));
    rstn = 1'b1;
    resp_tready = 1'b1;
    @(negedge clk);
    chk("post_rst_req_tready", 256'(req_tready), 256'(1));
    quiet(6, "post_rst_no_resp");
`ifdef LII_MEM_EP_ERR_CNT_EN
    chk("err_cnt_rst", 256'(err_cnt), 256'(0));
`endif
    ex[0] = 8'h11; ex[1] = 8'h22;
    do_read(48'h10, 8'd1, 3'd0, "rd_post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
